// File: rtl/ram_accumulator_if.sv
// Request bundle shared by the accumulator's write/accumulate port and its read port.
// Masters drive en/we/addr/wdata; the read slave returns rdata one cycle after a read.
interface ram_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 64
);
   logic                  en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;

   modport write_slave (input en, input we, input addr, input wdata);
   modport read_slave  (input en, input addr, output rdata);
   modport write_master (output en, output we, output addr, output wdata);
   modport read_master  (output en, output addr, input rdata);
endinterface

// File: rtl/ram_accumulator.sv
// RAM-backed accumulator: each word is overwritten or read-modify-write accumulated
// through a two-stage pipeline, one request per cycle, with same-address forwarding.
module ram_accumulator #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 64
) (
   input logic        clk,
   input logic        rstn,
   ram_if.write_slave wr_port,
   ram_if.read_slave  rd_port,
   input logic        mode
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_req;
   logic                  acc_req;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0] rd_data_reg;

   logic                  pipe_valid_reg;
   logic                  pipe_mode_reg;
   logic [ADDR_WIDTH-1:0] pipe_addr_reg;
   logic [DATA_WIDTH-1:0] pipe_wdata_reg;
   logic                  fwd_valid_reg;
   logic [DATA_WIDTH-1:0] fwd_data_reg;

   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] acc_operand;
   logic [DATA_WIDTH-1:0] commit_data;

   assign wr_req  = wr_port.en & wr_port.we;
   assign acc_req = wr_req & mode;

   // An accumulate steals the single RAM read port; a coincident external read is dropped.
   assign ram_rd_en   = acc_req | rd_port.en;
   assign ram_rd_addr = acc_req ? wr_port.addr : rd_port.addr;

   always_comb begin
      acc_operand = rd_data_reg;
      if (fwd_valid_reg) begin
         acc_operand = fwd_data_reg;
      end
      commit_data = pipe_wdata_reg;
      if (pipe_mode_reg) begin
         commit_data = acc_operand + pipe_wdata_reg;
      end
   end

   // The RAM read of an accumulate landing on the word being committed this edge would be stale.
   assign fwd_hit = acc_req & pipe_valid_reg & (pipe_addr_reg == wr_port.addr);

   // Read-first: the read sees the word before any commit at the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_reg <= '0;
      end else if (ram_rd_en) begin
         rd_data_reg <= mem[ram_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (pipe_valid_reg) begin
         mem[pipe_addr_reg] <= commit_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_valid_reg <= 1'b0;
         pipe_mode_reg  <= 1'b0;
         pipe_addr_reg  <= '0;
         pipe_wdata_reg <= '0;
         fwd_valid_reg  <= 1'b0;
         fwd_data_reg   <= '0;
      end else begin
         pipe_valid_reg <= wr_req;
         pipe_mode_reg  <= mode;
         pipe_addr_reg  <= wr_port.addr;
         pipe_wdata_reg <= wr_port.wdata;
         fwd_valid_reg  <= fwd_hit;
         if (fwd_hit) begin
            fwd_data_reg <= commit_data;
         end
      end
   end

   assign rd_port.rdata = rd_data_reg;

endmodule

// File: tb/tb_ram_accumulator.sv
// Directed and randomized checks of ram_accumulator against hand values and a reference model.
module tb_ram_accumulator;
   localparam int AW = 9;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic mode = 1'b0;

   ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_bus ();
   ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_bus ();

   ram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .wr_port (wr_bus),
      .rd_port (rd_bus),
      .mode    (mode)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] ref_mem [1 << AW];
   logic [DW-1:0] rd_val;
   logic [DW-1:0] exp_val;
   logic [DW-1:0] old_val;
   logic [DW-1:0] d;
   logic [AW-1:0] a;
   logic          m;
   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] pend_old;
   int            r;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic md);
      wr_bus.en    = 1'b1;
      wr_bus.we    = 1'b1;
      wr_bus.addr  = addr;
      wr_bus.wdata = data;
      mode         = md;
      @(posedge clk);
      #1;
      wr_bus.en = 1'b0;
      wr_bus.we = 1'b0;
      mode      = 1'b0;
      $display("wr   addr=%03h data=%0h mode=%0d", addr, data, md);
   endtask

   task automatic rd(input logic [AW-1:0] addr, output logic [DW-1:0] data);
      rd_bus.en   = 1'b1;
      rd_bus.addr = addr;
      @(posedge clk);
      #1;
      rd_bus.en = 1'b0;
      data      = rd_bus.rdata;
      $display("rd   addr=%03h data=%0h", addr, data);
   endtask

   initial begin
      wr_bus.en = 1'b0; wr_bus.we = 1'b0; wr_bus.addr = '0; wr_bus.wdata = '0;
      rd_bus.en = 1'b0; rd_bus.we = 1'b0; rd_bus.addr = '0; rd_bus.wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", rd_bus.rdata, 64'd0);
      rstn = 1'b1;

      // Overwrite
      wr(9'h010, 64'd100, 1'b0);
      wr(9'h020, 64'd200, 1'b0);
      idle(1);
      rd(9'h010, rd_val); check("ovw_10", rd_val, 64'd100);
      rd(9'h020, rd_val); check("ovw_20", rd_val, 64'd200);

      // Basic accumulate
      wr(9'h010, 64'd50, 1'b1);
      idle(1);
      rd(9'h010, rd_val); check("acc_basic", rd_val, 64'd150);

      // Back-to-back hazard, including overwrite forwarded into an accumulate
      wr(9'h050, 64'd0, 1'b0);
      for (int i = 0; i < 4; i++) wr(9'h050, 64'd10, 1'b1);
      idle(1);
      rd(9'h050, rd_val); check("hazard_4x10", rd_val, 64'd40);

      // Interleaved accumulates
      wr(9'h010, 64'd10, 1'b1);
      wr(9'h020, 64'd20, 1'b1);
      wr(9'h010, 64'd5, 1'b1);
      idle(1);
      rd(9'h010, rd_val); check("inter_10", rd_val, 64'd165);
      rd(9'h020, rd_val); check("inter_20", rd_val, 64'd220);

      // Overwrite and external read in the same cycle
      wr_bus.en = 1'b1; wr_bus.we = 1'b1; wr_bus.addr = 9'h080; wr_bus.wdata = 64'hDEADBEEF; mode = 1'b0;
      rd_bus.en = 1'b1; rd_bus.addr = 9'h010;
      @(posedge clk);
      #1;
      wr_bus.en = 1'b0; wr_bus.we = 1'b0; rd_bus.en = 1'b0;
      $display("wr+rd wr_addr=080 rd_addr=010 rdata=%0h", rd_bus.rdata);
      check("simul_rd", rd_bus.rdata, 64'd165);
      idle(1);
      rd(9'h080, rd_val); check("simul_wr", rd_val, 64'hDEADBEEF);
      idle(2);
      check("rdata_hold", rd_bus.rdata, 64'hDEADBEEF);

      // Accumulate with a dropped coincident external read
      wr_bus.en = 1'b1; wr_bus.we = 1'b1; wr_bus.addr = 9'h010; wr_bus.wdata = 64'd10; mode = 1'b1;
      rd_bus.en = 1'b1; rd_bus.addr = 9'h000;
      @(posedge clk);
      #1;
      wr_bus.en = 1'b0; wr_bus.we = 1'b0; mode = 1'b0; rd_bus.en = 1'b0;
      $display("acc+rd wr_addr=010 rd_addr=000");
      idle(1);
      rd(9'h010, rd_val); check("acc_drop_rd", rd_val, 64'd175);

      // Wrap-around of a single sum
      wr(9'h060, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      wr(9'h060, 64'd3, 1'b1);
      idle(1);
      rd(9'h060, rd_val); check("wrap", rd_val, 64'd2);

      // Request in flight at reset is discarded
      wr(9'h030, 64'd5, 1'b0);
      idle(1);
      wr_bus.en = 1'b1; wr_bus.we = 1'b1; wr_bus.addr = 9'h030; wr_bus.wdata = 64'd9; mode = 1'b0;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      wr_bus.en = 1'b0; wr_bus.we = 1'b0;
      #1;
      $display("reset asserted with write addr=030 in flight");
      check("reset_async_rdata", rd_bus.rdata, 64'd0);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      idle(1);
      rd(9'h030, rd_val); check("reset_discard", rd_val, 64'd5);

      // Scrub, then random traffic against the reference model
      for (int i = 0; i < (1 << AW); i++) begin
         wr_bus.en = 1'b1; wr_bus.we = 1'b1; wr_bus.addr = AW'(i); wr_bus.wdata = '0; mode = 1'b0;
         @(posedge clk);
         #1;
         ref_mem[i] = '0;
      end
      wr_bus.en = 1'b0; wr_bus.we = 1'b0;
      idle(2);
      $display("scrub done");

      pend_valid = 1'b0;
      pend_addr  = '0;
      pend_old   = '0;
      for (int n = 0; n < 10000; n++) begin
         r = $urandom_range(0, 99);
         a = AW'($urandom_range(0, 31));
         if (r < 70) begin
            m = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 1) == 1) d = {$urandom, $urandom};
            else d = 64'($urandom_range(0, 1000));
            wr_bus.en = 1'b1; wr_bus.we = 1'b1; wr_bus.addr = a; wr_bus.wdata = d; mode = m;
            @(posedge clk);
            #1;
            wr_bus.en = 1'b0; wr_bus.we = 1'b0; mode = 1'b0;
            old_val    = ref_mem[a];
            ref_mem[a] = m ? old_val + d : d;
            pend_valid = 1'b1;
            pend_addr  = a;
            pend_old   = old_val;
            $display("rnd  wr addr=%03h data=%0h mode=%0d", a, d, m);
         end else begin
            exp_val = (pend_valid && pend_addr == a) ? pend_old : ref_mem[a];
            rd_bus.en = 1'b1; rd_bus.addr = a;
            @(posedge clk);
            #1;
            rd_bus.en = 1'b0;
            $display("rnd  rd addr=%03h data=%0h", a, rd_bus.rdata);
            check("rand_rd", rd_bus.rdata, exp_val);
            pend_valid = 1'b0;
         end
      end
      idle(1);
      for (int i = 0; i < 32; i++) begin
         rd(AW'(i), rd_val);
         check("final_sweep", rd_val, ref_mem[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
